// File: rtl/operand_collector.sv
// operand_collector: synchronizes the 12-bit pin bus, qualifies tagged words,
// and assembles A -> B -> OP into num1/num2/op with a one-cycle start pulse.
module operand_collector #(
    parameter int WIDTH         = 10,
    parameter int OP_W          = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH+1:0]   inp,
    output logic [WIDTH-1:0]   num1,
    output logic [WIDTH-1:0]   num2,
    output logic [OP_W-1:0]    op,
    output logic               start,
    output logic               busy,
    output logic               err
);

    localparam int IW = WIDTH + 2;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, GOT_A, GOT_B} state_t;

    logic [IW-1:0]    sync_q [SYNC_STAGES];
    logic [IW-1:0]    prev_q;
    logic [IW-1:0]    synced;
    logic [1:0]       tag;
    logic [WIDTH-1:0] payload;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             accept;
    logic             is_a, is_b, is_op;

    state_t           state, nstate;
    logic [WIDTH-1:0] num1_d, num2_d;
    logic [OP_W-1:0]  op_d;
    logic             start_d, err_d;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign tag     = synced[IW-1 -: 2];
    assign payload = synced[WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            sync_q[0] <= inp;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            prev_q  <= synced;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    // Accept fires on the edge the run length reaches STABLE, once per tag.
    always_comb begin
        cnt_d = cnt_q;
        if (synced != prev_q)
            cnt_d = CW'(1);
        else if (tag != 2'b00 && cnt_q != STABLE)
            cnt_d = cnt_q + CW'(1);
        accept  = armed_q && (tag != 2'b00) && (cnt_d == STABLE);
        armed_d = armed_q;
        if (accept)
            armed_d = 1'b0;
        else if (tag == 2'b00)
            armed_d = 1'b1;
        is_a  = (tag == 2'b01);
        is_b  = (tag == 2'b10);
        is_op = (tag == 2'b11);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nstate;
    end

    always_comb begin
        nstate = state;
        if (accept) begin
            unique case (1'b1)
                is_a:    nstate = GOT_A;
                is_b:    if (state == GOT_A) nstate = GOT_B;
                is_op:   if (state == GOT_B) nstate = IDLE;
                default: nstate = state;
            endcase
        end
    end

    always_comb begin
        num1_d  = num1;
        num2_d  = num2;
        op_d    = op;
        err_d   = err;
        start_d = 1'b0;
        if (accept) begin
            unique case (1'b1)
                is_a: begin
                    num1_d = payload;
                    err_d  = 1'b0;
                end
                is_b: begin
                    if (state == GOT_A) num2_d = payload;
                    else                err_d  = 1'b1;
                end
                is_op: begin
                    if (state == GOT_B) begin
                        op_d    = payload[OP_W-1:0];
                        start_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: err_d = err;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            num1  <= '0;
            num2  <= '0;
            op    <= '0;
            start <= 1'b0;
            err   <= 1'b0;
        end else begin
            num1  <= num1_d;
            num2  <= num2_d;
            op    <= op_d;
            start <= start_d;
            err   <= err_d;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: pin-level transfers, a transfer-level model,
// and a start-pulse scoreboard checked by an independent monitor.
module tb_operand_collector;

    localparam int S = 2;
    localparam int T = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] inp   = '0;
    logic [9:0]  num1, num2;
    logic [3:0]  op;
    logic        start, busy, err;

    operand_collector dut (
        .clock (clock),
        .reset (reset),
        .inp   (inp),
        .num1  (num1),
        .num2  (num2),
        .op    (op),
        .start (start),
        .busy  (busy),
        .err   (err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] n1;
        logic [9:0] n2;
        logic [3:0] op;
        int         at;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: how many parts of the calculation are collected (0, 1 or 2).
    int         parts = 0;
    logic [9:0] m1 = '0, m2 = '0;
    logic [3:0] mop = '0;
    logic       merr = 1'b0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        parts = 0;
        m1 = '0;
        m2 = '0;
        mop = '0;
        merr = 1'b0;
    endtask

    task automatic model_accept(input logic [1:0] tag, input logic [9:0] pl,
                                input int c0);
        exp_t e;
        case (tag)
            2'b01: begin
                m1 = pl;
                merr = 1'b0;
                parts = 1;
            end
            2'b10: begin
                if (parts == 1) begin
                    m2 = pl;
                    parts = 2;
                end else merr = 1'b1;
            end
            default: begin
                if (parts == 2) begin
                    mop = pl[3:0];
                    parts = 0;
                    e.n1 = m1;
                    e.n2 = m2;
                    e.op = mop;
                    e.at = c0 + S + T;
                    q.push_back(e);
                end else merr = 1'b1;
            end
        endcase
    endtask

    // Pin word held for `hold` edges, then 00 for `gap` edges.
    task automatic xfer(input logic [1:0] tag, input logic [9:0] pl,
                        input int hold, input int gap);
        int c0;
        @(negedge clock);
        inp = {tag, pl};
        c0 = cyc;
        if (tag != 2'b00 && hold >= T)
            model_accept(tag, pl, c0);
        repeat (hold) @(negedge clock);
        inp = '0;
        repeat (gap - 1) @(negedge clock);
    endtask

    task automatic settle(input string tname);
        repeat (6) @(negedge clock);
        cmp({tname, "_num1"}, num1, m1);
        cmp({tname, "_num2"}, num2, m2);
        cmp({tname, "_op"}, op, mop);
        cmp({tname, "_err"}, err, merr);
        cmp({tname, "_busy"}, busy, parts != 0);
        cmp({tname, "_start"}, start, 0);
    endtask

    task automatic do_reset(input string tname);
        @(negedge clock);
        reset = 1'b1;
        inp = '0;
        #1;
        model_clear();
        cmp({tname, "_rst_num1"}, num1, 0);
        cmp({tname, "_rst_num2"}, num2, 0);
        cmp({tname, "_rst_op"}, op, 0);
        cmp({tname, "_rst_flags"}, {start, busy, err}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (start) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start got 1 expected 0 at cycle %0d",
                             cyc);
                end else begin
                    e = q.pop_front();
                    cmp("start_num1", num1, e.n1);
                    cmp("start_num2", num2, e.n2);
                    cmp("start_op", op, e.op);
                    cmp("start_cycle", cyc, e.at);
                    cmp("start_busy", busy, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int want;
        logic [1:0] tg;
        repeat (3) @(negedge clock);
        cmp("reset_num1", num1, 0);
        cmp("reset_flags", {start, busy, err}, 0);
        reset = 1'b0;

        // short-lived tag is ignored
        xfer(2'b01, 10'h3FF, 1, 3);
        settle("glitch");

        // basic sequence
        xfer(2'b01, 10'h155, 6, 3);
        settle("t1_a");
        xfer(2'b10, 10'h0AA, 6, 3);
        settle("t1_b");
        xfer(2'b11, 10'h003, 6, 3);
        settle("t1_op");

        // long OP hold gives one start; repeated OP is an error
        xfer(2'b01, 10'h012, 6, 2);
        xfer(2'b10, 10'h034, 6, 2);
        xfer(2'b11, 10'h007, 20, 3);
        xfer(2'b11, 10'h007, 6, 3);
        settle("t2");

        // OP from idle, then a full sequence clears err
        xfer(2'b11, 10'h005, 6, 3);
        settle("t4_err");
        xfer(2'b01, 10'h0F0, 6, 3);
        settle("t4_a");
        xfer(2'b10, 10'h00F, 6, 3);
        xfer(2'b11, 10'h3F5, 6, 3);
        settle("t4");

        // A overwrites A; minimum hold length accepted
        xfer(2'b01, 10'h001, 2, 1);
        xfer(2'b01, 10'h2F0, 2, 1);
        xfer(2'b10, 10'h010, 2, 1);
        xfer(2'b11, 10'h00F, 2, 1);
        settle("t5");

        // reset mid-sequence
        xfer(2'b01, 10'h111, 6, 3);
        xfer(2'b10, 10'h222, 6, 3);
        settle("t6_pre");
        do_reset("t6");
        xfer(2'b11, 10'h009, 6, 3);
        settle("t6");

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            want = (parts == 0) ? 1 : (parts == 1) ? 2 : 3;
            if ($urandom_range(0, 9) < 6) tg = 2'(want);
            else tg = 2'($urandom_range(1, 3));
            xfer(tg, 10'($urandom), $urandom_range(1, 5), $urandom_range(1, 3));
            if (i % 10 == 9) settle("rand");
        end

        settle("final");
        cmp("pending_starts", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
